pwm_capture: RTL and testbench

- Measures an incoming PWM waveform and reports its high time and period in clock cycles.
- Counterpart to the PWM generator: it decodes a PWM stream rather than producing one.
- Used for loopback self-check of the valve-drive PWM and for reading PWM-encoded flow-sensor feedback.
- Sits beside the PWM generator in the top level, on the 100 MHz board clock.

---
 rtl/pwm_capture.sv | 169 ++++++++++++++++
 tb/tb_pwm_capture.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
`timescale 1ns/1ps
// PWM capture: measures high time and period of pwm_in in clk cycles, flags a stuck input.
// Optional glitch filter after the synchronizer: define PWM_CAPTURE_GLITCH_FILTER_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | after reset, waiting for the first rise (partial period)
// ST_HIGH  | input high inside a period being measured
// ST_LOW   | input low, next rise completes the period
// ST_STUCK | no rise for TIMEOUT cycles, stuck_high/stuck_low asserted
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 50000,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic             stuck_high,
  output logic             stuck_low
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HIGH  = 2'd1;
  localparam logic [1:0] ST_LOW   = 2'd2;
  localparam logic [1:0] ST_STUCK = 2'd3;

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  if (TIMEOUT < 2 || TIMEOUT > (2 ** CNT_W) - 2 || SYNC_STAGES < 2 || FILT_LEN < 1) begin : g_param_check
    $error("pwm_capture: parameter out of range");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_sync;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic                   fall;
  logic                   timeout_hit;
  logic [CNT_W-1:0]       per_acc;
  logic [CNT_W-1:0]       hi_acc;
  logic [1:0]             state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
    end
  end

  assign s_sync = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int FC_W = $clog2(FILT_LEN + 1);

  logic [FC_W-1:0] filt_cnt;
  logic            s_filt;

  // s_filt follows s_sync only after FILT_LEN consecutive disagreeing samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_cnt <= '0;
      s_filt   <= 1'b0;
    end else if (s_sync == s_filt) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FC_W'(FILT_LEN - 1)) begin
      s_filt   <= s_sync;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign s = s_filt;
`else
  assign s = s_sync;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_d <= 1'b0;
    end else begin
      s_d <= s;
    end
  end

  assign rise        = s & ~s_d;
  assign fall        = ~s & s_d;
  assign timeout_hit = (per_acc == TO_VAL);

  // Both accumulators saturate at TIMEOUT so a stuck input never wraps them
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      per_acc <= '0;
      hi_acc  <= '0;
    end else if (rise) begin
      per_acc <= ONE;
      hi_acc  <= ONE;
    end else begin
      if (per_acc != TO_VAL) per_acc <= per_acc + ONE;
      if (s && hi_acc != TO_VAL) hi_acc <= hi_acc + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      high_cnt   <= '0;
      period_cnt <= '0;
      meas_valid <= 1'b0;
      stuck_high <= 1'b0;
      stuck_low  <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rise) begin
            state <= ST_HIGH;
          end else if (timeout_hit) begin
            state      <= ST_STUCK;
            stuck_high <= s;
            stuck_low  <= ~s;
          end
        end
        ST_HIGH: begin
          if (fall) begin
            state <= ST_LOW;
          end else if (timeout_hit) begin
            state      <= ST_STUCK;
            stuck_high <= s;
            stuck_low  <= ~s;
          end
        end
        ST_LOW: begin
          // rise takes priority over a coincident timeout
          if (rise) begin
            high_cnt   <= hi_acc;
            period_cnt <= per_acc;
            meas_valid <= 1'b1;
            state      <= ST_HIGH;
          end else if (timeout_hit) begin
            state      <= ST_STUCK;
            stuck_high <= s;
            stuck_low  <= ~s;
          end
        end
        ST_STUCK: begin
          if (rise) begin
            stuck_high <= 1'b0;
            stuck_low  <= 1'b0;
            state      <= ST_HIGH;
          end else if (fall) begin
            stuck_high <= 1'b0;
            stuck_low  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
`timescale 1ns/1ps
// Self-checking bench for pwm_capture: measurements predicted from driven edge timestamps.
module tb_pwm_capture;

  localparam int CNT_W       = 16;
  localparam int TIMEOUT     = 300;
  localparam int SYNC_STAGES = 2;
  localparam int FILT_LEN    = 4;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int LAT = SYNC_STAGES + 1 + FILT_LEN;
`else
  localparam int LAT = SYNC_STAGES + 1;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             meas_valid;
  logic             stuck_high;
  logic             stuck_low;

  pwm_capture #(
    .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)
  ) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in),
    .high_cnt(high_cnt), .period_cnt(period_cnt), .meas_valid(meas_valid),
    .stuck_high(stuck_high), .stuck_low(stuck_low)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int hi; int per; int at; } meas_t;
  meas_t exp_q[$];
  meas_t got_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // model state: timestamps of the last driven rise and fall
  bit m_armed = 1'b0;
  int m_rise  = 0;
  int m_fall  = 0;

  always @(negedge clk) begin : mon
    meas_t m;
    if (meas_valid) begin
      m.hi  = int'(high_cnt);
      m.per = int'(period_cnt);
      m.at  = cyc;
      got_q.push_back(m);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // A period is reported when the next rise arrives within TIMEOUT cycles of its own rise.
  task automatic set_pwm(input logic v, input bit rec);
    meas_t m;
    if (rec) begin
      if (v && !pwm_in) begin
        if (m_armed && (cyc - m_rise) <= TIMEOUT) begin
          m.hi  = m_fall - m_rise;
          m.per = cyc - m_rise;
          m.at  = cyc + LAT;
          exp_q.push_back(m);
        end
        m_armed = 1'b1;
        m_rise  = cyc;
      end else if (!v && pwm_in) begin
        m_fall = cyc;
      end
    end
    pwm_in = v;
  endtask

  task automatic pwm_period(input int h, input int p);
    set_pwm(1'b1, 1'b1);
    wait_cyc(h);
    set_pwm(1'b0, 1'b1);
    wait_cyc(p - h);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    set_pwm(1'b0, 1'b0);
    m_armed = 1'b0;
    wait_cyc(3);
    rst = 1'b1;
    wait_cyc(1);
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    wait_cyc(3);
    n_checks++;
    if (high_cnt !== '0 || period_cnt !== '0 || meas_valid !== 1'b0 || stuck_high !== 1'b0 || stuck_low !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got hc=%0d pc=%0d mv=%b sh=%b sl=%b, expected all 0", high_cnt, period_cnt, meas_valid, stuck_high, stuck_low);
    end
    rst = 1'b1;
    m_armed = 1'b0;
    wait_cyc(5);
    n_checks++;
    if (high_cnt !== '0 || period_cnt !== '0 || meas_valid !== 1'b0 || stuck_high !== 1'b0 || stuck_low !== 1'b0) begin
      n_fail++;
      $display("FAIL after_release: got hc=%0d pc=%0d mv=%b sh=%b sl=%b, expected all 0", high_cnt, period_cnt, meas_valid, stuck_high, stuck_low);
    end
  endtask

  task automatic test_basic();
    exp_q.delete(); got_q.delete();
    apply_reset();
    for (int i = 0; i < 6; i++) pwm_period(30, 100);
    wait_cyc(LAT + 2);
    n_checks++;
    if (got_q.size() != 5 || exp_q.size() != 5) begin
      n_fail++;
      $display("FAIL basic_count: got %0d measurements (model %0d), expected 5", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i].hi != 30 || got_q[i].per != 100 || got_q[i].at != exp_q[i].at) begin
        n_fail++;
        $display("FAIL basic[%0d]: got hi=%0d per=%0d at=%0d, expected hi=30 per=100 at=%0d", i, got_q[i].hi, got_q[i].per, got_q[i].at, exp_q[i].at);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_duty_change();
    for (int i = 0; i < 3; i++) pwm_period(30, 100);
    for (int i = 0; i < 4; i++) pwm_period(75, 100);
    wait_cyc(LAT + 2);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL duty_count: got %0d measurements, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i].hi != exp_q[i].hi || got_q[i].per != exp_q[i].per || got_q[i].at != exp_q[i].at) begin
        n_fail++;
        $display("FAIL duty[%0d]: got hi=%0d per=%0d at=%0d, expected hi=%0d per=%0d at=%0d", i, got_q[i].hi, got_q[i].per, got_q[i].at, exp_q[i].hi, exp_q[i].per, exp_q[i].at);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_stuck_high();
    for (int i = 0; i < 2; i++) pwm_period(30, 100);
    set_pwm(1'b1, 1'b1);
    wait_cyc(TIMEOUT + 10);
    n_checks++;
    if (stuck_high !== 1'b1 || stuck_low !== 1'b0 || high_cnt !== 16'd30 || period_cnt !== 16'd100) begin
      n_fail++;
      $display("FAIL stuck_high: got sh=%b sl=%b hc=%0d pc=%0d, expected sh=1 sl=0 hc=30 pc=100", stuck_high, stuck_low, high_cnt, period_cnt);
    end
    set_pwm(1'b0, 1'b1);
    wait_cyc(LAT + 5);
    n_checks++;
    if (stuck_high !== 1'b0 || stuck_low !== 1'b1) begin
      n_fail++;
      $display("FAIL stuck_swap: got sh=%b sl=%b, expected sh=0 sl=1", stuck_high, stuck_low);
    end
    wait_cyc(60);
    set_pwm(1'b1, 1'b1);
    wait_cyc(LAT + 2);
    n_checks++;
    if (stuck_high !== 1'b0 || stuck_low !== 1'b0) begin
      n_fail++;
      $display("FAIL stuck_clear: got sh=%b sl=%b, expected both 0", stuck_high, stuck_low);
    end
    wait_cyc(30 - LAT - 2);
    set_pwm(1'b0, 1'b1);
    wait_cyc(70);
    for (int i = 0; i < 3; i++) pwm_period(30, 100);
    wait_cyc(LAT + 2);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL stuck_count: got %0d measurements, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i].hi != exp_q[i].hi || got_q[i].per != exp_q[i].per || got_q[i].at != exp_q[i].at) begin
        n_fail++;
        $display("FAIL stuck[%0d]: got hi=%0d per=%0d at=%0d, expected hi=%0d per=%0d at=%0d", i, got_q[i].hi, got_q[i].per, got_q[i].at, exp_q[i].hi, exp_q[i].per, exp_q[i].at);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_timeout_boundary();
    for (int i = 0; i < 3; i++) pwm_period(10, TIMEOUT);
    pwm_period(10, TIMEOUT + 1);
    for (int i = 0; i < 3; i++) pwm_period(10, 100);
    wait_cyc(LAT + 2);
    n_checks++;
    if (stuck_high !== 1'b0 || stuck_low !== 1'b0) begin
      n_fail++;
      $display("FAIL boundary_flags: got sh=%b sl=%b, expected both 0", stuck_high, stuck_low);
    end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL boundary_count: got %0d measurements, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i].hi != exp_q[i].hi || got_q[i].per != exp_q[i].per || got_q[i].at != exp_q[i].at) begin
        n_fail++;
        $display("FAIL boundary[%0d]: got hi=%0d per=%0d at=%0d, expected hi=%0d per=%0d at=%0d", i, got_q[i].hi, got_q[i].per, got_q[i].at, exp_q[i].hi, exp_q[i].per, exp_q[i].at);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_random();
    int h;
    int l;
    for (int i = 0; i < 25; i++) begin
      h = $urandom_range(60, 6);
      l = $urandom_range(80, 6);
      pwm_period(h, h + l);
    end
    wait_cyc(LAT + 2);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL random_count: got %0d measurements, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i].hi != exp_q[i].hi || got_q[i].per != exp_q[i].per || got_q[i].at != exp_q[i].at) begin
        n_fail++;
        $display("FAIL random[%0d]: got hi=%0d per=%0d at=%0d, expected hi=%0d per=%0d at=%0d", i, got_q[i].hi, got_q[i].per, got_q[i].at, exp_q[i].hi, exp_q[i].per, exp_q[i].at);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_glitch();
    bit rec_glitch;
    int n_short;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    rec_glitch = 1'b0;
`else
    rec_glitch = 1'b1;
`endif
    for (int i = 0; i < 2; i++) pwm_period(30, 100);
    set_pwm(1'b1, 1'b1);
    wait_cyc(30);
    set_pwm(1'b0, 1'b1);
    wait_cyc(20);
    set_pwm(1'b1, rec_glitch);
    wait_cyc(2);
    set_pwm(1'b0, rec_glitch);
    wait_cyc(48);
    for (int i = 0; i < 3; i++) pwm_period(30, 100);
    wait_cyc(LAT + 2);
    n_short = 0;
    foreach (got_q[i]) if (got_q[i].per < 100) n_short++;
    n_checks++;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    if (n_short != 0) begin
      n_fail++;
      $display("FAIL glitch_short: got %0d short periods, expected 0", n_short);
    end
`else
    if (n_short == 0) begin
      n_fail++;
      $display("FAIL glitch_short: got 0 short periods, expected at least 1");
    end
`endif
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL glitch_count: got %0d measurements, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i].hi != exp_q[i].hi || got_q[i].per != exp_q[i].per || got_q[i].at != exp_q[i].at) begin
        n_fail++;
        $display("FAIL glitch[%0d]: got hi=%0d per=%0d at=%0d, expected hi=%0d per=%0d at=%0d", i, got_q[i].hi, got_q[i].per, got_q[i].at, exp_q[i].hi, exp_q[i].per, exp_q[i].at);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_midperiod();
    for (int i = 0; i < 2; i++) pwm_period(30, 100);
    set_pwm(1'b1, 1'b1);
    wait_cyc(30);
    set_pwm(1'b0, 1'b1);
    wait_cyc(20);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    n_checks++;
    if (high_cnt !== '0 || period_cnt !== '0 || meas_valid !== 1'b0 || stuck_high !== 1'b0 || stuck_low !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got hc=%0d pc=%0d mv=%b sh=%b sl=%b, expected all 0", high_cnt, period_cnt, meas_valid, stuck_high, stuck_low);
    end
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    m_armed = 1'b0;
    @(negedge clk);
    wait_cyc(10);
    for (int i = 0; i < 3; i++) pwm_period(30, 100);
    wait_cyc(LAT + 2);
    n_checks++;
    if (got_q.size() != exp_q.size() || got_q.size() < 3) begin
      n_fail++;
      $display("FAIL reset_mid_count: got %0d measurements, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i].hi != exp_q[i].hi || got_q[i].per != exp_q[i].per || got_q[i].at != exp_q[i].at) begin
        n_fail++;
        $display("FAIL reset_mid[%0d]: got hi=%0d per=%0d at=%0d, expected hi=%0d per=%0d at=%0d", i, got_q[i].hi, got_q[i].per, got_q[i].at, exp_q[i].hi, exp_q[i].per, exp_q[i].at);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_stuck_low();
    exp_q.delete(); got_q.delete();
    apply_reset();
    wait_cyc(TIMEOUT + 5);
    n_checks++;
    if (stuck_low !== 1'b1 || stuck_high !== 1'b0 || high_cnt !== '0 || period_cnt !== '0) begin
      n_fail++;
      $display("FAIL stuck_low: got sl=%b sh=%b hc=%0d pc=%0d, expected sl=1 sh=0 hc=0 pc=0", stuck_low, stuck_high, high_cnt, period_cnt);
    end
    n_checks++;
    if (got_q.size() != 0) begin
      n_fail++;
      $display("FAIL stuck_low_meas: got %0d measurements, expected 0", got_q.size());
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_duty_change();
    test_stuck_high();
    test_timeout_boundary();
    test_random();
    test_glitch();
    test_reset_midperiod();
    test_stuck_low();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
